// File: rtl/phase_period_filter.sv
// phase_period_filter
// Post-processing for the phase detector's period measurement: keeps a moving
// average over the last 2^AVG_LOG2 nonzero periods, converts the average into
// a scaled frequency with a 48-step restoring divider, and flags timeouts.
// Optional feature macro: PHASE_LOCK_EN builds the frequency-lock comparator;
// without it `locked` is tied low and LOCK_TOL/LOCK_CNT have no effect.
module phase_period_filter #(
  parameter longint unsigned CLK_HZ     = 40_000_000,
  parameter longint unsigned FREQ_SCALE = 100,
  parameter int unsigned     AVG_LOG2   = 3,
  parameter int unsigned     LOCK_TOL   = 4000,
  parameter int unsigned     LOCK_CNT   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        period_valid,
  input  logic [31:0] period_in,
  output logic [31:0] avg_period,
  output logic [31:0] freq_out,
  output logic        out_valid,
  output logic        locked,
  output logic        timeout
);

  localparam int DEPTH  = 1 << AVG_LOG2;
  localparam int PTR_W  = (AVG_LOG2 > 0) ? int'(AVG_LOG2) : 1;
  localparam int SUM_W  = 32 + int'(AVG_LOG2);
  localparam int FILL_W = int'(AVG_LOG2) + 1;

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [47:0]       NUMER     = 48'(CLK_HZ * FREQ_SCALE);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Reject configurations the datapath widths cannot represent.
  if (AVG_LOG2 > 6 || LOCK_CNT == 0 || LOCK_CNT > 255 || LOCK_TOL > 32'h7FFF_FFFF) begin : g_bad_cfg
    $error("phase_period_filter: unsupported AVG_LOG2, LOCK_CNT or LOCK_TOL");
  end

  logic [31:0]       samples_q [DEPTH];
  logic [SUM_W-1:0]  sum_q;
  logic [FILL_W-1:0] fill_q;
  logic [PTR_W-1:0]  ptr_q;

  logic        sample_nz;
  logic        sample_zero;
  logic        buf_full;
  logic        fills_now;
  logic [31:0] oldest;
  logic [31:0] avg_now;

  logic [1:0]  state_q;
  logic        pending_q;
  logic [31:0] rem_q;
  logic [31:0] div_q;
  logic [47:0] quo_q;
  logic [5:0]  iter_q;

  logic [32:0] rem_shift;
  logic        rem_ge;
  logic [31:0] rem_next;

  // Sample classification, buffer bookkeeping and one restoring-division step.
  // Entries beyond the fill count are stale after a flush, so they subtract as 0.
  always_comb begin
    sample_nz   = period_valid && (period_in != 32'd0);
    sample_zero = period_valid && (period_in == 32'd0);
    buf_full    = (fill_q == FILL_FULL);
    fills_now   = buf_full || (fill_q == FILL_FULL - FILL_W'(1));
    oldest      = buf_full ? samples_q[ptr_q] : 32'd0;
    avg_now     = sum_q[AVG_LOG2 +: 32];
    rem_shift   = {rem_q, quo_q[47]};
    rem_ge      = (rem_shift >= {1'b0, div_q});
    rem_next    = rem_ge ? 32'(rem_shift - {1'b0, div_q}) : rem_shift[31:0];
  end

  // Circular sample buffer, running sum and timeout flag; updates in any FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) samples_q[i] <= '0;
      sum_q   <= '0;
      fill_q  <= '0;
      ptr_q   <= '0;
      timeout <= 1'b0;
    end else if (sample_zero) begin
      sum_q   <= '0;
      fill_q  <= '0;
      ptr_q   <= '0;
      timeout <= 1'b1;
    end else if (sample_nz) begin
      samples_q[ptr_q] <= period_in;
      sum_q   <= sum_q - SUM_W'(oldest) + SUM_W'(period_in);
      fill_q  <= buf_full ? fill_q : fill_q + FILL_W'(1);
      ptr_q   <= (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);
      timeout <= 1'b0;
    end
  end

  // Averaging/divide sequencer: LOAD latches the average, DIV runs 48 steps,
  // DONE publishes the saturated quotient; samples mid-divide queue one rerun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pending_q  <= 1'b0;
      avg_period <= '0;
      freq_out   <= '0;
      out_valid  <= 1'b0;
      rem_q      <= '0;
      div_q      <= '0;
      quo_q      <= '0;
      iter_q     <= '0;
    end else begin
      out_valid <= 1'b0;
      if (sample_zero) begin
        state_q   <= S_IDLE;
        pending_q <= 1'b0;
        freq_out  <= '0;
        out_valid <= 1'b1;
        iter_q    <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (sample_nz && fills_now) state_q <= S_LOAD;
          end
          S_LOAD: begin
            avg_period <= avg_now;
            div_q      <= avg_now;
            rem_q      <= '0;
            iter_q     <= '0;
            if (sample_nz) pending_q <= 1'b1;
            if (avg_now == 32'd0) begin
              quo_q   <= '1;
              state_q <= S_DONE;
            end else begin
              quo_q   <= NUMER;
              state_q <= S_DIV;
            end
          end
          S_DIV: begin
            rem_q  <= rem_next;
            quo_q  <= {quo_q[46:0], rem_ge};
            iter_q <= iter_q + 6'd1;
            if (sample_nz) pending_q <= 1'b1;
            if (iter_q == 6'd47) state_q <= S_DONE;
          end
          S_DONE: begin
            freq_out  <= (|quo_q[47:32]) ? 32'hFFFF_FFFF : quo_q[31:0];
            out_valid <= 1'b1;
            pending_q <= 1'b0;
            state_q   <= (pending_q || sample_nz) ? S_LOAD : S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

`ifdef PHASE_LOCK_EN
  localparam logic [7:0] LOCK_MAX = 8'(LOCK_CNT);

  logic [7:0]  lock_cnt_q;
  logic [31:0] lock_diff;
  logic        lock_in_tol;

  // Distance of the new sample from the currently published average.
  always_comb begin
    lock_diff   = (period_in >= avg_period) ? (period_in - avg_period) : (avg_period - period_in);
    lock_in_tol = (lock_diff <= 32'(LOCK_TOL));
  end

  // Consecutive in-tolerance counter; any outlier or timeout drops lock at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_cnt_q <= '0;
      locked     <= 1'b0;
    end else if (sample_zero) begin
      lock_cnt_q <= '0;
      locked     <= 1'b0;
    end else if (sample_nz && buf_full) begin
      if (lock_in_tol) begin
        if (lock_cnt_q < LOCK_MAX) lock_cnt_q <= lock_cnt_q + 8'd1;
        if (lock_cnt_q >= LOCK_MAX - 8'd1) locked <= 1'b1;
      end else begin
        lock_cnt_q <= '0;
        locked     <= 1'b0;
      end
    end
  end
`else
  assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_phase_period_filter.sv
// Testbench for phase_period_filter: directed steps plus randomized periods,
// checked against a queue-based reference model of the averaging filter.
module tb_phase_period_filter;

  localparam longint unsigned CLK_HZ     = 40_000_000;
  localparam longint unsigned SAT_CLK_HZ = 1_000_000_000;
  localparam longint unsigned FREQ_SCALE = 100;
  localparam longint unsigned NUMER      = CLK_HZ * FREQ_SCALE;
  localparam longint unsigned NUMER_SAT  = SAT_CLK_HZ * FREQ_SCALE;
  localparam int              DEPTH      = 8;
`ifdef PHASE_LOCK_EN
  localparam longint unsigned LOCK_TOL   = 4000;
  localparam int              LOCK_CNT   = 4;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        period_valid = 1'b0;
  logic [31:0] period_in = 32'd0;
  logic [31:0] avg_period, freq_out;
  logic        out_valid, locked, timeout;
  logic [31:0] sat_avg, sat_freq;
  logic        sat_valid, sat_locked, sat_timeout;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int unsigned     hist[$];
  logic            expTimeout = 1'b0;
  logic            expLocked = 1'b0;
  int              lockCount = 0;
  longint unsigned modelAvgReg = 0;

  always #5 clk = ~clk;

  phase_period_filter #(
    .CLK_HZ(CLK_HZ), .FREQ_SCALE(FREQ_SCALE), .AVG_LOG2(3), .LOCK_TOL(4000), .LOCK_CNT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .period_valid(period_valid), .period_in(period_in),
    .avg_period(avg_period), .freq_out(freq_out), .out_valid(out_valid),
    .locked(locked), .timeout(timeout)
  );

  phase_period_filter #(
    .CLK_HZ(SAT_CLK_HZ), .FREQ_SCALE(FREQ_SCALE), .AVG_LOG2(3), .LOCK_TOL(4000), .LOCK_CNT(4)
  ) dut_sat (
    .clk(clk), .rst_n(rst_n), .period_valid(period_valid), .period_in(period_in),
    .avg_period(sat_avg), .freq_out(sat_freq), .out_valid(sat_valid),
    .locked(sat_locked), .timeout(sat_timeout)
  );

  function automatic longint unsigned modelAvg();
    longint unsigned s = 0;
    foreach (hist[i]) s += longint'(hist[i]);
    return s / DEPTH;
  endfunction

  function automatic logic [31:0] modelFreq(input longint unsigned numer, input longint unsigned avg);
    longint unsigned q;
    if (avg == 0) return 32'hFFFF_FFFF;
    q = numer / avg;
    if (q > 64'hFFFF_FFFF) return 32'hFFFF_FFFF;
    return q[31:0];
  endfunction

  function automatic void modelReset();
    hist.delete();
    expTimeout  = 1'b0;
    expLocked   = 1'b0;
    lockCount   = 0;
    modelAvgReg = 0;
  endfunction

  function automatic void modelSample(input logic [31:0] p);
`ifdef PHASE_LOCK_EN
    longint unsigned pv;
    longint unsigned diff;
`endif
    if (p == 32'd0) begin
      hist.delete();
      expTimeout = 1'b1;
      expLocked  = 1'b0;
      lockCount  = 0;
    end else begin
      expTimeout = 1'b0;
`ifdef PHASE_LOCK_EN
      if (hist.size() == DEPTH) begin
        pv   = longint'(p);
        diff = (pv >= modelAvgReg) ? pv - modelAvgReg : modelAvgReg - pv;
        if (diff <= LOCK_TOL) begin
          if (lockCount < LOCK_CNT) lockCount++;
          if (lockCount == LOCK_CNT) expLocked = 1'b1;
        end else begin
          lockCount = 0;
          expLocked = 1'b0;
        end
      end
`endif
      hist.push_back(int'(p));
      if (hist.size() > DEPTH) void'(hist.pop_front());
      if (hist.size() == DEPTH) modelAvgReg = modelAvg();
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h (%0d), expected 0x%08h (%0d)", tag, observed, observed, expected, expected);
    end
  endtask

  // One-cycle strobe; returns #1 after the edge that registered the sample.
  task automatic applyStimulus(input logic [31:0] p);
    @(posedge clk);
    #1;
    period_valid = 1'b1;
    period_in    = p;
    modelSample(p);
    @(posedge clk);
    #1;
    period_valid = 1'b0;
    period_in    = 32'd0;
  endtask

  task automatic waitValid(input int maxCycles, output int cycles, output bit seen);
    seen   = 1'b0;
    cycles = 0;
    while (!seen && cycles < maxCycles) begin
      @(posedge clk);
      #1;
      cycles++;
      if (out_valid) seen = 1'b1;
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_avg", avg_period, 32'd0);
    checkOutput("reset_freq", freq_out, 32'd0);
    checkOutput("reset_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_locked", 32'(locked), 32'd0);
    checkOutput("reset_timeout", 32'(timeout), 32'd0);
    checkOutput("reset_sat_outputs", {sat_freq[31:3], sat_valid, sat_locked, sat_timeout}, 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    int cycles;
    bit seen;
    logic [31:0] aAvg, aFreq, r;

    $display("[TB] start");
    doReset();

    // Fill: no output until the buffer holds eight samples
    for (int i = 0; i < 7; i++) begin
      applyStimulus(32'd400_000);
      waitValid(60, cycles, seen);
      checkOutput("no_early_valid", 32'(seen), 32'd0);
    end
    applyStimulus(32'd400_000);
    waitValid(100, cycles, seen);
    checkOutput("first_valid_seen", 32'(seen), 32'd1);
    checkOutput("first_latency", 32'(cycles), 32'd50);
    checkOutput("first_avg", avg_period, 32'd400_000);
    checkOutput("first_freq", freq_out, 32'd10_000);
    checkOutput("sat_dut_freq_400k", sat_freq, modelFreq(NUMER_SAT, modelAvgReg));

    // Lock acquisition with small offsets, then loss on an outlier
    for (int i = 0; i < 4; i++) begin
      applyStimulus(32'd402_000);
      checkOutput("lock_step_locked", 32'(locked), 32'(expLocked));
      checkOutput("lock_step_timeout", 32'(timeout), 32'd0);
      waitValid(100, cycles, seen);
      checkOutput("lock_step_valid", 32'(seen), 32'd1);
      checkOutput("lock_step_avg", avg_period, 32'(modelAvgReg));
      checkOutput("lock_step_freq", freq_out, modelFreq(NUMER, modelAvgReg));
    end
`ifdef PHASE_LOCK_EN
    checkOutput("locked_after_4", 32'(locked), 32'd1);
`else
    checkOutput("locked_tied_low", 32'(locked), 32'd0);
`endif
    applyStimulus(32'd410_000);
    checkOutput("unlock_far_sample", 32'(locked), 32'd0);
    waitValid(100, cycles, seen);
    checkOutput("far_sample_freq", freq_out, modelFreq(NUMER, modelAvgReg));

    // Second sample arrives mid-divide: two pulses, second reflects both
    applyStimulus(32'd404_000);
    aAvg  = 32'(modelAvgReg);
    aFreq = modelFreq(NUMER, modelAvgReg);
    repeat (9) @(posedge clk);
    applyStimulus(32'd398_000);
    waitValid(120, cycles, seen);
    checkOutput("pending_first_valid", 32'(seen), 32'd1);
    checkOutput("pending_first_avg", avg_period, aAvg);
    checkOutput("pending_first_freq", freq_out, aFreq);
    waitValid(120, cycles, seen);
    checkOutput("pending_second_valid", 32'(seen), 32'd1);
    checkOutput("pending_second_avg", avg_period, 32'(modelAvgReg));
    checkOutput("pending_second_freq", freq_out, modelFreq(NUMER, modelAvgReg));
    waitValid(120, cycles, seen);
    checkOutput("pending_no_third", 32'(seen), 32'd0);

    // Timeout while dividing aborts the divide
    applyStimulus(32'd400_000);
    repeat (19) @(posedge clk);
    applyStimulus(32'd0);
    checkOutput("timeout_valid_pulse", 32'(out_valid), 32'd1);
    checkOutput("timeout_freq_zero", freq_out, 32'd0);
    checkOutput("timeout_flag", 32'(timeout), 32'(expTimeout));
    checkOutput("timeout_locked", 32'(locked), 32'd0);
    checkOutput("timeout_avg_holds", avg_period, 32'(modelAvgReg));
    waitValid(80, cycles, seen);
    checkOutput("timeout_divide_aborted", 32'(seen), 32'd0);

    // Refill after timeout: eight fresh random samples needed
    r = 32'($urandom_range(390_000, 410_000));
    applyStimulus(r);
    checkOutput("timeout_cleared", 32'(timeout), 32'd0);
    for (int i = 0; i < 6; i++) begin
      waitValid(60, cycles, seen);
      checkOutput("refill_no_valid", 32'(seen), 32'd0);
      r = 32'($urandom_range(390_000, 410_000));
      applyStimulus(r);
    end
    waitValid(60, cycles, seen);
    checkOutput("refill_no_valid", 32'(seen), 32'd0);
    r = 32'($urandom_range(390_000, 410_000));
    applyStimulus(r);
    waitValid(100, cycles, seen);
    checkOutput("refill_valid", 32'(seen), 32'd1);
    checkOutput("refill_avg", avg_period, 32'(modelAvgReg));
    checkOutput("refill_freq", freq_out, modelFreq(NUMER, modelAvgReg));

    // Randomized steady-state samples
    for (int i = 0; i < 10; i++) begin
      r = 32'($urandom_range(390_000, 410_000));
      applyStimulus(r);
      checkOutput("rand_locked", 32'(locked), 32'(expLocked));
      checkOutput("rand_timeout", 32'(timeout), 32'd0);
      waitValid(100, cycles, seen);
      checkOutput("rand_valid", 32'(seen), 32'd1);
      checkOutput("rand_avg", avg_period, 32'(modelAvgReg));
      checkOutput("rand_freq", freq_out, modelFreq(NUMER, modelAvgReg));
    end

    // Tiny period: fits at 40 MHz, saturates at 1 GHz
    doReset();
    for (int i = 0; i < 8; i++) applyStimulus(32'd8);
    waitValid(100, cycles, seen);
    checkOutput("small_valid", 32'(seen), 32'd1);
    checkOutput("small_freq", freq_out, modelFreq(NUMER, 8));
    checkOutput("sat_avg", sat_avg, 32'd8);
    checkOutput("sat_valid", 32'(sat_valid), 32'd1);
    checkOutput("sat_freq_model", sat_freq, modelFreq(NUMER_SAT, 8));
    checkOutput("sat_freq_all_ones", sat_freq, 32'hFFFF_FFFF);

    // Asynchronous reset in the middle of a divide
    applyStimulus(32'd8);
    repeat (20) @(posedge clk);
    #3;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("async_reset_avg", avg_period, 32'd0);
    checkOutput("async_reset_freq", freq_out, 32'd0);
    checkOutput("async_reset_valid", 32'(out_valid), 32'd0);
    checkOutput("async_reset_locked", 32'(locked), 32'd0);
    checkOutput("async_reset_timeout", 32'(timeout), 32'd0);
    checkOutput("async_reset_sat_freq", sat_freq, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed no completion, expected finish within 2 ms");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
